// File: rtl/mult_seq_32b.sv
// Sequential shift-add unsigned multiplier. It computes one partial product per
// cycle in CALC and gives a WIDTH x WIDTH -> 2*WIDTH product after WIDTH steps.
module mult_seq_32b #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   shifted;

    // The carry of each add lands in the top bit of the shifted accumulator,
    // so the cleared carry bit between steps needs no storage of its own.
    always_comb begin
        addend  = acc_q[0] ? mcand_q : '0;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        shifted = {sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = shifted;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    product_d = shifted;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == CALC);
    assign done    = (state_q == DONE);
    assign product = product_q;

endmodule

// File: tb/tb_mult_seq_32b.sv
// Scoreboard bench for mult_seq_32b: stimulus pushes expected products and done
// cycles, and a negedge monitor checks every done pulse against the queue.
module tb_mult_seq_32b;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [63:0] product;

    typedef struct {
        logic [63:0] prod;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned vectors;
    int unsigned miscompares;
    logic [63:0] last_prod;

    mult_seq_32b #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a_i),
        .b       (b_i),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation in value and cycle.
    initial last_prod = '0;
    always @(negedge clk) begin
        if (reset) begin
            last_prod = '0;
        end else if (done) begin
            check("busy_done_exclusive", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", product, e.prod);
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
            last_prod = product;
        end else begin
            check("product_hold", product, last_prod);
        end
    end

    // Presents operands with start high for one edge; caller is #1 past a posedge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] exp, input bit expect_done);
        exp_t e;
        a_i   = av;
        b_i   = bv;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        a_i   = $urandom;
        b_i   = $urandom;
        if (expect_done) begin
            e.prod = exp;
            e.cyc  = cyc + 32;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input bit count_busy);
        int unsigned busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        if (count_busy) check("busy_cycles", 64'(busy_cnt), 64'd32);
    endtask

    task automatic run_mult(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] exp);
        @(posedge clk) #1;
        issue(av, bv, exp, 1'b1);
        wait_done(1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_product", product, 64'd0);
        @(posedge clk) #1;
        reset = 1'b0;

        run_mult(32'd10, 32'd15, 64'd150);
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_mult(32'd229, 32'd0, 64'd0);
        run_mult(32'd0, 32'd114, 64'd0);

        // Second start during CALC must be ignored.
        @(posedge clk) #1;
        issue(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        a_i   = 32'd3;
        b_i   = 32'd3;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        wait_done(1'b0);
        repeat (40) @(negedge clk);
        check("no_queued_start", 64'(sb.size()), 64'd0);

        // Reset mid-CALC aborts: outputs clear at once and no done follows.
        @(posedge clk) #1;
        issue(32'd7, 32'd9, 64'd63, 1'b0);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        @(posedge clk) #1;
        reset = 1'b0;
        issue(32'd6, 32'd7, 64'd42, 1'b1);
        wait_done(1'b1);

        // Start held high: accepted every 34 cycles.
        @(posedge clk) #1;
        a_i   = 32'd3;
        b_i   = 32'd5;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            @(posedge clk) #1;
            e.prod = 64'd15;
            e.cyc  = cyc + 32;
            sb.push_back(e);
            if (k < 2) repeat (33) @(posedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_seq_32b.md
MULT_SEQ_32B -- requirements
Module: mult_seq_32b

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; product width is 2*WIDTH; all values below are for WIDTH=32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port a, input, 32, unsigned multiplicand; captured on the accepting edge.
REQ-006 SHALL have port b, input, 32, unsigned multiplier; captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1, high while a multiply is in progress (state CALC).
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking that product is valid.
REQ-009 SHALL have port product, output, 64, result register.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-011 In IDLE with start=1 at a rising edge, SHALL capture a into the multiplicand register, load b into the low half of the accumulator, clear the high half and carry bit, clear the iteration counter, and move to CALC.
REQ-012 In IDLE with start=0, SHALL remain in IDLE with all registers unchanged.
REQ-013 In CALC, each cycle SHALL perform one shift-add step: if accumulator bit 0 is 1, add the multiplicand to the high 32 bits with a 33-bit result (carry kept); then shift the 65-bit {carry, high, low} right by one.
REQ-014 The iteration counter SHALL be 6 bits wide and increment once per CALC cycle; after the 32nd step (counter value 31 at the edge), SHALL move to DONE.
REQ-015 On entering DONE, SHALL load product with the 64-bit accumulator; product SHALL then hold that value until the next DONE entry or reset.
REQ-016 done SHALL be 1 for exactly the one cycle spent in DONE; DONE SHALL always return to IDLE on the next edge.
REQ-017 Latency: start accepted at edge N -> busy high in cycles N..N+31, done high in the cycle after edge N+32, product valid from edge N+32; minimum start-to-start spacing is 34 cycles.
REQ-018 start asserted in CALC or DONE SHALL be ignored; it is not queued; a and b changes during CALC SHALL NOT affect the result.
REQ-019 The result SHALL equal the exact unsigned product a*b mod 2^64; overflow is impossible; no carry or overflow output exists.
REQ-020 Operands 0 SHALL still take the full 32 CALC cycles (no early termination).
REQ-021 busy and done SHALL never both be 1; busy=0 and done=0 in IDLE.

Reset
REQ-022 reset=1 SHALL immediately, without waiting for a clock edge, force state to IDLE and clear busy, done, product, accumulator, multiplicand and counter to 0.
REQ-023 reset asserted mid-CALC SHALL abort the operation; no done pulse for it SHALL ever appear.
REQ-024 After reset deasserts, a start at the first following edge SHALL be accepted normally.

Verification
REQ-025 a=10, b=15, start for one cycle -> busy high for 32 cycles, done pulse one cycle later, product=150.
REQ-026 a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001, done after 33 cycles.
REQ-027 a=229, b=0, then a=0, b=114 -> product=0 each time, each still 33 cycles to done.
REQ-028 a=0x80000000, b=2 started; at cycle 5 start=1 with a=3, b=3 -> second start ignored, product=0x0000000100000000, single done pulse.
REQ-029 a=7, b=9 started; reset pulsed at cycle 10 -> busy, done and product=0 at once, no done pulse; then a=6, b=7 started -> product=42.
REQ-030 Back-to-back: start held high continuously with a=3, b=5 -> done pulses every 34 cycles, product=15 each time, product stable between pulses.
